// File: rtl/coin_vend_ctrl.sv
// Coin-acceptance controller: synchronises four coin lines, accumulates credit against PRICE, drives vend handshake and refund/change pulses.
// Latency: coin sampled at edge k shows in credit after edge k+2; vend/refund decision one edge after credit reaches PRICE.
// Backpressure: vend is held until vend_ack; coins arriving while busy (VEND/REFUND) are rejected, not queued.
//
// Ports:
//   clk, rst            sole clock (rising edge), synchronous active-high reset
//   coin_in_i[3:0]      raw asynchronous coin pulses, bit i worth VALi
//   cancel_i            level cancel request (ignored outside ACCUM)
//   vend_ack_i          motor stage has taken the vend (ignored outside VEND)
//   vend_o              vend request, held until acknowledged
//   refund_o            one-cycle refund/change pulse, refund_amt_o valid with it
//   refund_amt_o        amount to dump, 0 when refund_o is low
//   credit_o            current accumulated credit
//   coin_reject_o       one-cycle pulse: a coin arrived while busy
//   busy_o              high in VEND or REFUND
module coin_vend_ctrl #(
    parameter int PRICE     = 51,
    parameter int SUM_W     = 8,
    parameter int VAL0      = 25,
    parameter int VAL1      = 10,
    parameter int VAL2      = 5,
    parameter int VAL3      = 1,
    parameter int CHANGE_EN = 0,
    parameter int TIMEOUT   = 1000,
    parameter int TO_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       coin_in_i,
    input  logic             cancel_i,
    input  logic             vend_ack_i,
    output logic             vend_o,
    output logic             refund_o,
    output logic [SUM_W-1:0] refund_amt_o,
    output logic [SUM_W-1:0] credit_o,
    output logic             coin_reject_o,
    output logic             busy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_REFUND = 2'd3;

    localparam logic [SUM_W-1:0] V0      = SUM_W'(VAL0);
    localparam logic [SUM_W-1:0] V1      = SUM_W'(VAL1);
    localparam logic [SUM_W-1:0] V2      = SUM_W'(VAL2);
    localparam logic [SUM_W-1:0] V3      = SUM_W'(VAL3);
    localparam logic [SUM_W-1:0] PRICE_C = SUM_W'(PRICE);
    localparam logic [TO_W-1:0]  TO_C    = TO_W'(TIMEOUT);

    // Parameter sanity: credit must never wrap, and the timeout must fit its counter.
    if (PRICE + VAL0 + VAL1 + VAL2 + VAL3 > (1 << SUM_W) - 1) begin : g_bad_sum_w
        $error("coin_vend_ctrl: SUM_W too narrow for PRICE plus coin values");
    end
    if (TIMEOUT < 1 || (1 << TO_W) <= TIMEOUT) begin : g_bad_timeout
        $error("coin_vend_ctrl: TIMEOUT must be >= 1 and < 2**TO_W");
    end

    // Input synchroniser plus one extra registered copy for rising-edge detect.
    logic [3:0] sync1_q, sync2_q, prev_q;
    logic [3:0] coin_edge;
    logic       any_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= coin_in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign coin_edge = sync2_q & ~prev_q;
    assign any_edge  = |coin_edge;

    // Simultaneous coins are summed into a single increment.
    logic [SUM_W-1:0] inc;
    always_comb begin
        inc = '0;
        if (coin_edge[0]) inc = inc + V0;
        if (coin_edge[1]) inc = inc + V1;
        if (coin_edge[2]) inc = inc + V2;
        if (coin_edge[3]) inc = inc + V3;
    end

    logic [1:0]       state_q, state_d;
    logic [SUM_W-1:0] credit_q, credit_d;
    logic [TO_W-1:0]  to_q, to_d, to_inc;
    logic             refund_q, refund_d;
    logic [SUM_W-1:0] amt_q, amt_d;
    logic             reject_q, reject_d;

    assign to_inc = to_q + TO_W'(1);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        to_d     = to_q;
        refund_d = 1'b0;
        amt_d    = '0;
        reject_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_edge) begin
                    credit_d = inc;
                    to_d     = '0;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // A coin in the exit cycle is still credited, so it lands in
                // the vend change or the refund.
                credit_d = credit_q + inc;
                to_d     = any_edge ? '0 : to_inc;
                if (credit_q == PRICE_C) begin
                    state_d = S_VEND;
                end else if (credit_q > PRICE_C) begin
                    state_d = (CHANGE_EN != 0) ? S_VEND : S_REFUND;
                end else if (cancel_i) begin
                    state_d = S_REFUND;
                end else if (!any_edge && to_inc == TO_C) begin
                    // Fires on the edge at which the idle count reaches TIMEOUT.
                    state_d = S_REFUND;
                end
                // Refund pulse is registered so it coincides with the REFUND state.
                if (state_d == S_REFUND) begin
                    refund_d = 1'b1;
                    amt_d    = credit_d;
                end
            end
            S_VEND: begin
                reject_d = any_edge;
                if (vend_ack_i) begin
                    state_d  = S_IDLE;
                    credit_d = '0;
                    if (credit_q > PRICE_C) begin
                        refund_d = 1'b1;
                        amt_d    = credit_q - PRICE_C;
                    end
                end
            end
            default: begin
                // S_REFUND: the pulse was issued on entry; this cycle just drains.
                reject_d = any_edge;
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            to_q     <= '0;
            refund_q <= 1'b0;
            amt_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            to_q     <= to_d;
            refund_q <= refund_d;
            amt_q    <= amt_d;
            reject_q <= reject_d;
        end
    end

    assign vend_o        = (state_q == S_VEND);
    assign busy_o        = (state_q == S_VEND) || (state_q == S_REFUND);
    assign refund_o      = refund_q;
    assign refund_amt_o  = amt_q;
    assign credit_o      = credit_q;
    assign coin_reject_o = reject_q;

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Directed bench: two controllers (full refund vs. change-giving) driven with the same stimulus.
module tb_coin_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] coin_in = 4'b0;
    logic       cancel = 1'b0;
    logic       vend_ack = 1'b0;

    logic       vend0, refund0, reject0, busy0;
    logic [7:0] amt0, credit0;
    logic       vend1, refund1, reject1, busy1;
    logic [7:0] amt1, credit1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    coin_vend_ctrl #(.CHANGE_EN(0), .TIMEOUT(20), .TO_W(5)) dut0 (
        .clk(clk), .rst(rst), .coin_in_i(coin_in), .cancel_i(cancel), .vend_ack_i(vend_ack),
        .vend_o(vend0), .refund_o(refund0), .refund_amt_o(amt0), .credit_o(credit0),
        .coin_reject_o(reject0), .busy_o(busy0)
    );

    coin_vend_ctrl #(.CHANGE_EN(1), .TIMEOUT(20), .TO_W(5)) dut1 (
        .clk(clk), .rst(rst), .coin_in_i(coin_in), .cancel_i(cancel), .vend_ack_i(vend_ack),
        .vend_o(vend1), .refund_o(refund1), .refund_amt_o(amt1), .credit_o(credit1),
        .coin_reject_o(reject1), .busy_o(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse coin bits for one cycle; returns just after the edge at which credit updates.
    task automatic coin(input logic [3:0] mask);
        coin_in = mask;
        tick();
        coin_in = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({vend0, refund0, reject0, busy0} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {vend0, refund0, reject0, busy0});
        end
        n_tests++;
        if (credit0 !== 8'd0 || amt0 !== 8'd0) begin
            n_fail++; $display("FAIL reset_values: credit %0d amt %0d want 0 0", credit0, amt0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_exact_vend();
        coin(4'b0001);
        n_tests++;
        if (credit0 !== 8'd25) begin n_fail++; $display("FAIL credit_25: got %0d want 25", credit0); end
        coin(4'b0001);
        n_tests++;
        if (credit0 !== 8'd50) begin n_fail++; $display("FAIL credit_50: got %0d want 50", credit0); end
        coin(4'b1000);
        n_tests++;
        if (credit0 !== 8'd51 || vend0 !== 1'b0) begin
            n_fail++; $display("FAIL credit_51: credit %0d vend %b want 51 0", credit0, vend0);
        end
        tick();
        n_tests++;
        if (vend0 !== 1'b1 || busy0 !== 1'b1 || vend1 !== 1'b1) begin
            n_fail++; $display("FAIL exact_vend: vend0 %b busy0 %b vend1 %b want 1 1 1", vend0, busy0, vend1);
        end
        tick();
        tick();
        n_tests++;
        if (vend0 !== 1'b1) begin n_fail++; $display("FAIL vend_hold: got %b want 1", vend0); end
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        n_tests++;
        if (vend0 !== 1'b0 || refund0 !== 1'b0 || credit0 !== 8'd0 || refund1 !== 1'b0) begin
            n_fail++; $display("FAIL exact_ack: vend %b refund0 %b credit %0d refund1 %b want 0 0 0 0",
                               vend0, refund0, credit0, refund1);
        end
        tick();
    endtask

    task automatic test_overpay();
        coin(4'b0001);
        coin(4'b0001);
        coin(4'b0100);
        n_tests++;
        if (credit0 !== 8'd55 || credit1 !== 8'd55) begin
            n_fail++; $display("FAIL credit_55: got %0d %0d want 55 55", credit0, credit1);
        end
        tick();
        n_tests++;
        if (refund0 !== 1'b1 || amt0 !== 8'd55 || vend0 !== 1'b0) begin
            n_fail++; $display("FAIL overpay_refund: refund %b amt %0d vend %b want 1 55 0", refund0, amt0, vend0);
        end
        n_tests++;
        if (vend1 !== 1'b1 || refund1 !== 1'b0) begin
            n_fail++; $display("FAIL change_vend: vend %b refund %b want 1 0", vend1, refund1);
        end
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        n_tests++;
        if (refund1 !== 1'b1 || amt1 !== 8'd4 || vend1 !== 1'b0 || credit1 !== 8'd0) begin
            n_fail++; $display("FAIL change_pulse: refund %b amt %0d vend %b credit %0d want 1 4 0 0",
                               refund1, amt1, vend1, credit1);
        end
        n_tests++;
        if (refund0 !== 1'b0 || amt0 !== 8'd0 || credit0 !== 8'd0 || vend0 !== 1'b0) begin
            n_fail++; $display("FAIL overpay_after: refund %b amt %0d credit %0d vend %b want 0 0 0 0",
                               refund0, amt0, credit0, vend0);
        end
        tick();
    endtask

    task automatic test_simul_and_reject();
        coin(4'b1001);
        n_tests++;
        if (credit0 !== 8'd26) begin n_fail++; $display("FAIL simul_coins: got %0d want 26", credit0); end
        coin(4'b0001);
        tick();
        n_tests++;
        if (vend0 !== 1'b1 || credit0 !== 8'd51) begin
            n_fail++; $display("FAIL simul_vend: vend %b credit %0d want 1 51", vend0, credit0);
        end
        coin(4'b0010);
        n_tests++;
        if (reject0 !== 1'b1 || credit0 !== 8'd51 || vend0 !== 1'b1) begin
            n_fail++; $display("FAIL busy_reject: reject %b credit %0d vend %b want 1 51 1", reject0, credit0, vend0);
        end
        tick();
        n_tests++;
        if (reject0 !== 1'b0) begin n_fail++; $display("FAIL reject_pulse: got %b want 0", reject0); end
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        n_tests++;
        if (vend0 !== 1'b0 || credit0 !== 8'd0 || refund1 !== 1'b0) begin
            n_fail++; $display("FAIL simul_ack: vend %b credit %0d refund1 %b want 0 0 0", vend0, credit0, refund1);
        end
        tick();
    endtask

    task automatic test_timeout();
        bit early = 1'b0;
        coin(4'b0010);
        n_tests++;
        if (credit0 !== 8'd10) begin n_fail++; $display("FAIL credit_10: got %0d want 10", credit0); end
        for (int i = 1; i < 20; i++) begin
            tick();
            if (refund0 !== 1'b0) early = 1'b1;
        end
        n_tests++;
        if (early) begin n_fail++; $display("FAIL timeout_early: refund seen before 20 cycles, want none"); end
        tick();
        n_tests++;
        if (refund0 !== 1'b1 || amt0 !== 8'd10 || refund1 !== 1'b1) begin
            n_fail++; $display("FAIL timeout_refund: refund %b amt %0d refund1 %b want 1 10 1", refund0, amt0, refund1);
        end
        tick();
        n_tests++;
        if (credit0 !== 8'd0 || refund0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after: credit %0d refund %b busy %b want 0 0 0", credit0, refund0, busy0);
        end
    endtask

    task automatic test_cancel();
        coin(4'b0100);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_tests++;
        if (refund0 !== 1'b1 || amt0 !== 8'd5 || busy0 !== 1'b1) begin
            n_fail++; $display("FAIL cancel_refund: refund %b amt %0d busy %b want 1 5 1", refund0, amt0, busy0);
        end
        tick();
        n_tests++;
        if (credit0 !== 8'd0 || refund0 !== 1'b0) begin
            n_fail++; $display("FAIL cancel_after: credit %0d refund %b want 0 0", credit0, refund0);
        end
    endtask

    task automatic test_reset_mid_vend();
        coin(4'b0001);
        coin(4'b0001);
        coin(4'b1000);
        tick();
        n_tests++;
        if (vend0 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_vend: got %b want 1", vend0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (vend0 !== 1'b0 || credit0 !== 8'd0 || busy0 !== 1'b0 || refund0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_vend: vend %b credit %0d busy %b refund %b want 0 0 0 0",
                               vend0, credit0, busy0, refund0);
        end
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        n_tests++;
        if (refund0 !== 1'b0 || vend0 !== 1'b0 || credit0 !== 8'd0) begin
            n_fail++; $display("FAIL stray_ack: refund %b vend %b credit %0d want 0 0 0", refund0, vend0, credit0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_exact_vend();
        test_overpay();
        test_simul_and_reject();
        test_timeout();
        test_cancel();
        test_reset_mid_vend();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_vend_ctrl.md
# coin_vend_ctrl

Clocked, parametrised coin-acceptance controller. It takes four raw coin-sensor lines and synchronises and edge-detects them, then accumulates credit against a programmable price. It drives a vend handshake to the motor stage, and issues refunds or change to the change-dump stage. It supersedes the unclocked coin checker, adding configurable coin values, optional change-giving, cancel, inactivity timeout and rejection of coins while busy.

## Interface
- PRICE, 51: credit value at which a vend is granted.
- SUM_W, 8: width of credit and refund_amt; PRICE + max coin value must be ≤ 2^SUM_W−1 (elaboration-time check, no overflow path).
- VAL0 / VAL1 / VAL2 / VAL3, 25 / 10 / 5 / 1: value of coin_in[0..3].
- CHANGE_EN, 0: 1 = vend on overpay and return the excess; 0 = refund the whole credit on overpay.
- TIMEOUT, 1000: idle cycles in ACCUM before an automatic full refund; must be ≥1.
- TO_W, 10: timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_in  in  4  raw asynchronous coin pulses, one bit per denomination.
- cancel  in  1  user cancel request, level, sampled each cycle.
- vend_ack  in  1  motor stage has taken the vend.
- vend  out  1  vend request, held until acknowledged.
- refund  out  1  one-cycle pulse; refund_amt valid in the same cycle.
- refund_amt  out  SUM_W  amount to dump; 0 when refund is low.
- credit  out  SUM_W  current accumulated credit.
- coin_reject  out  1  one-cycle pulse: a coin arrived while the controller was not accepting.
- busy  out  1  high in VEND or REFUND.

## Operation
- Input path: coin_in goes through a 2-flop synchroniser per bit, then rising-edge detection against a third registered copy. Each detected edge counts as one coin.
- Coin add: same-cycle edges are summed. The increment is Σ VALi × edge_i, added to credit in a single cycle.
- States: IDLE, ACCUM, VEND, REFUND.
- IDLE: credit = 0. Any coin edge adds its value to credit and moves to ACCUM.
- ACCUM: coins add to credit. The timeout counter clears on every coin edge and increments otherwise. Exit conditions are evaluated on the registered credit, in priority order:
  1. credit == PRICE → VEND.
  2. credit > PRICE → VEND if CHANGE_EN is 1, else REFUND.
  3. cancel → REFUND.
  4. counter == TIMEOUT → REFUND.
- Coin and cancel in the same cycle: the coin is credited and included in the refund.
- VEND: vend = 1 until vend_ack is sampled high. In that cycle:
  - if credit > PRICE, refund pulses with refund_amt = credit − PRICE;
  - credit clears to 0 and the next state is IDLE.
  - cancel is ignored in VEND.
- REFUND: lasts one cycle. refund = 1 and refund_amt = credit; credit clears to 0; the next state is IDLE.
- A coin edge in VEND or REFUND is not credited and raises coin_reject for one cycle.
- vend_ack outside VEND is ignored.

## Timing
- Reset (rst high at a clk edge):
  - state = IDLE;
  - credit, refund_amt, timeout counter = 0;
  - vend, refund, coin_reject, busy = 0;
  - synchroniser and edge flops = 0.
- Reset wins over every other input. Reset mid-VEND drops vend on the next edge and does not refund (credit is lost by design).
- Coin latency: coin_in is first sampled high at edge k; credit shows the new value after edge k+2.
- Decision latency: credit reaching or exceeding PRICE after edge n gives vend or refund high after edge n+1.
- vend_ack high at edge m gives vend low after edge m.
  - The change pulse occupies the same cycle (after m); credit is 0 after m.
  - A one-cycle vend_ack pulse is sufficient.
- Coins arriving back-to-back in consecutive cycles are each counted. coin_in must be low for ≥2 cycles between pulses on the same bit.
- Timeout: the REFUND decision is taken at the edge where the counter equals TIMEOUT. The counter is then TIMEOUT cycles past the last coin edge.
- busy equals (state == VEND or state == REFUND), registered.

## Test plan
- Defaults: coins 25, 25, 1 → credit 25, 50, 51 → vend = 1 one cycle later. Pulse vend_ack → vend = 0, no refund, credit 0.
- CHANGE_EN = 0: coins 25, 25, 5 → one refund pulse with refund_amt = 55, vend never asserts, credit 0.
- CHANGE_EN = 1: coins 25, 25, 5 → vend = 1. Pulse vend_ack → refund pulse with refund_amt = 4 in the ack cycle.
- coin_in[0] and coin_in[3] rising in the same cycle → credit increments by 26 in one step. A coin during VEND → coin_reject pulse, credit unchanged.
- TIMEOUT = 20: coin 10, then idle → refund_amt = 10 exactly 20 cycles after the credit edge. Cancel after coin 5 → refund_amt = 5.
- Reset while vend is held (credit 51) → after the reset edge: vend = 0, credit = 0, state IDLE, no refund pulse.
